// File: rtl/jtcop_dispgate.sv
// Display-bus access gate for the main 68000: serialises CPU accesses to CH display
// chip-selects against the blanking window and reports stall statistics for debug.
module jtcop_dispgate #(
  parameter int CH        = 4,
  parameter int CNTW      = 3,
  parameter int DLY       = 2,
  parameter int HBLANK_OK = 1,
  parameter int ABORT     = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cen,
  input  logic          LVBL,
  input  logic          LHBL,
  input  logic [CH-1:0] cs,
  input  logic [CH-1:0] free_mask,
  output logic          busy,
  output logic [CH-1:0] grant,
  output logic [15:0]   wait_cnt,
  output logic          multi_err
);

  typedef enum logic [1:0] {IDLE, WAIT, COUNT, DONE} state_t;

  state_t          state, state_nx;
  logic            any_cs, any_cs_l, start, blank, sel_free, multi;
  logic [CH-1:0]   sel_oh;
  logic [CNTW-1:0] cnt;

  assign any_cs   = |cs;
  assign start    = any_cs & ~any_cs_l;
  assign blank    = ~LVBL | ((HBLANK_OK != 0) & ~LHBL);
  // lowest set bit of cs wins; any further set bit flags a multi-select
  assign sel_oh   = cs & (~cs + CH'(1));
  assign multi    = |(cs & (cs - CH'(1)));
  // once granted, the served channel is remembered by the one-hot grant itself
  assign sel_free = |(free_mask & grant);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = ((|(free_mask & sel_oh)) | blank) ? COUNT : WAIT;
      WAIT:  if (!any_cs)    state_nx = IDLE;
             else if (blank) state_nx = COUNT;
      COUNT: if (!any_cs)                                   state_nx = IDLE;
             else if ((ABORT != 0) && !sel_free && !blank)  state_nx = WAIT;
             else if (cnt == '0)                            state_nx = DONE;
      DONE:  if (!any_cs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = any_cs & (state != DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant     <= '0;
      cnt       <= '0;
      wait_cnt  <= '0;
      multi_err <= 1'b0;
      any_cs_l  <= 1'b0;
    end else begin
      any_cs_l <= any_cs;
      if ((state == WAIT || state == COUNT) && cpu_cen && wait_cnt != '1)
        wait_cnt <= wait_cnt + 16'd1;
      if (state == IDLE) begin
        if (start) begin
          grant     <= sel_oh;
          wait_cnt  <= '0;
          multi_err <= multi_err | multi;
        end
      end else if (!any_cs) begin
        grant <= '0;
      end
      // reload on every entry to COUNT so an aborted count restarts from DLY
      if (state_nx == COUNT && state != COUNT)
        cnt <= CNTW'(DLY);
      else if (state == COUNT && state_nx == COUNT && cpu_cen && cnt != '0)
        cnt <= cnt - CNTW'(1);
    end
  end

endmodule

// File: tb/tb_jtcop_dispgate.sv
// Directed bench for jtcop_dispgate: blank gating, free channels, abort, multi-select,
// cancel/reset and wait counter saturation, with cpu_cen every 4th clock unless noted.
module tb_jtcop_dispgate;

  logic       clk = 1'b0;
  logic       rst, cpu_cen, LVBL, LHBL;
  logic [3:0] cs, free_mask, grant;
  logic       busy, multi_err;
  logic [15:0] wait_cnt;

  int unsigned ph;
  logic        cen_all;
  int          n_tests = 0;
  int          n_fail  = 0;

  jtcop_dispgate #(.CH(4), .CNTW(3), .DLY(2), .HBLANK_OK(1), .ABORT(1)) dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .LVBL(LVBL), .LHBL(LHBL),
    .cs(cs), .free_mask(free_mask), .busy(busy), .grant(grant),
    .wait_cnt(wait_cnt), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one clock: sample point is 1 ns after the rising edge; cpu_cen for the next edge is set here
  task automatic step();
    @(posedge clk);
    #1;
    ph++;
    cpu_cen = cen_all | ((ph % 4) == 0);
  endtask

  task automatic phase0();
    ph = 0;
    cpu_cen = cen_all;
  endtask

  initial begin
    rst = 1'b0; cs = '0; free_mask = '0; LVBL = 1'b1; LHBL = 1'b1;
    cen_all = 1'b0; ph = 0; cpu_cen = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_wait", wait_cnt, 0);
    check("rst_multi", multi_err, 0);
    rst = 1'b1;
    step();

    // free channel during active display
    phase0();
    free_mask = 4'b0100; cs = 4'b0100;
    #1;
    check("free_busy_comb", busy, 1);
    step();
    check("free_grant_e1", grant, 4'b0100);
    repeat (8) step();
    check("free_busy_e9", busy, 1);
    step();
    check("free_busy_done", busy, 0);
    check("free_grant", grant, 4'b0100);
    check("free_wait", wait_cnt, 2);
    repeat (3) step();
    check("held_cs_no_restart", busy, 0);
    cs = '0; free_mask = '0;
    step();
    check("free_grant_clr", grant, 0);

    // blank-gated access waits for vblank
    phase0();
    cs = 4'b0001;
    repeat (8) step();
    check("gate_busy_wait", busy, 1);
    check("gate_grant", grant, 4'b0001);
    check("gate_wait_mid", wait_cnt, 1);
    LVBL = 1'b0;
    repeat (9) step();
    check("gate_busy_cnt", busy, 1);
    step();
    check("gate_busy_done", busy, 0);
    check("gate_wait", wait_cnt, 4);
    LVBL = 1'b1; cs = '0;
    step();

    // abort when hblank closes mid-count, complete in the next hblank
    phase0();
    LHBL = 1'b0; cs = 4'b0001;
    repeat (5) step();
    LHBL = 1'b1;
    step();
    check("abort_busy", busy, 1);
    repeat (4) step();
    check("abort_busy_wait", busy, 1);
    check("abort_wait_mid", wait_cnt, 2);
    LHBL = 1'b0;
    repeat (7) step();
    check("abort_busy_cnt", busy, 1);
    step();
    check("abort_busy_done", busy, 0);
    check("abort_wait", wait_cnt, 4);
    check("abort_grant", grant, 4'b0001);
    LHBL = 1'b1; cs = '0;
    step();

    // multi-select, then cancel from WAIT
    phase0();
    cs = 4'b0110;
    step();
    check("multi_grant", grant, 4'b0010);
    check("multi_flag", multi_err, 1);
    check("multi_busy", busy, 1);
    cs = '0;
    step();
    check("cancel_grant", grant, 0);
    check("cancel_busy", busy, 0);
    check("multi_sticky", multi_err, 1);

    // reset in COUNT
    phase0();
    LVBL = 1'b0; cs = 4'b1000;
    step(); step();
    check("cnt_grant", grant, 4'b1000);
    rst = 1'b0; cs = '0; LVBL = 1'b1;
    step();
    check("rstc_busy", busy, 0);
    check("rstc_grant", grant, 0);
    check("rstc_wait", wait_cnt, 0);
    check("rstc_multi", multi_err, 0);
    rst = 1'b1;
    step();

    // wait counter saturation with cpu_cen every clock
    cen_all = 1'b1;
    phase0();
    cs = 4'b0001;
    repeat (65540) step();
    check("sat_wait", wait_cnt, 16'hFFFF);
    check("sat_busy", busy, 1);
    step();
    check("sat_hold", wait_cnt, 16'hFFFF);
    cs = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtcop_dispgate.md
Name: jtcop_dispgate

Overview:
- Parametrised display-bus access gate for the main 68000.
- Generalises the single display-lock scheme to CH independent display chip-selects (tilemap, scroll, mode and second-PCB BAC06 regions).
- Each channel is either blank-gated or free with a fixed penalty.
- Drives the `bus_busy` contribution into jtframe_68kdtack and keeps per-access stall statistics for debug.

Parameters:
- CH, 4, number of display chip-select channels.
- CNTW, 3, width of the acknowledge delay counter.
- DLY, 2, cpu_cen ticks between grant and data-good; must be ≤ 2^CNTW−1.
- HBLANK_OK, 1, when 1 the horizontal blank also opens the access window; when 0 only the vertical blank does.
- ABORT, 1, when 1 an access whose blank window closes before the count completes returns to waiting.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset. Synchronous, active-low.
- cpu_cen, in, 1, CPU clock enable; all delay counting advances only on it.
- LVBL, in, 1, vertical blank, active low.
- LHBL, in, 1, horizontal blank, active low.
- cs, in, CH, display chip-selects, already qualified by /AS.
- free_mask, in, CH, 1 = channel accessible outside blank, still with the DLY penalty.
- busy, out, 1, stall request to the DTACK generator.
- grant, out, CH, one-hot channel currently served or completed.
- wait_cnt, out, 16, cpu_cen ticks stalled by the last or current access; saturating.
- multi_err, out, 1, sticky flag: more than one cs bit seen at access start.

Behaviour:
- Access window: blank = ~LVBL | (HBLANK_OK & ~LHBL).
- any_cs = |cs, registered each clk as any_cs_l. Access start = any_cs & ~any_cs_l.
- Channel selection at access start: sel = lowest-index set bit of cs.
  - If more than one bit is set, multi_err is set and stays set until reset.
  - The other channels are ignored for this access.
- Reset (rst low at a clk edge): state=IDLE, grant=0, cnt=0, wait_cnt=0, multi_err=0, any_cs_l=0. Reset applied mid-access discards that access.
- busy is combinational: busy = any_cs & (state != DONE). It rises in the same cycle as cs, with no registered lag.
- States:
  - IDLE: on access start, grant=onehot(sel) and wait_cnt=0.
    - If free_mask[sel] | blank, go to COUNT with cnt=DLY.
    - Otherwise go to WAIT.
  - WAIT: when blank is high at a clk edge, go to COUNT with cnt=DLY. Otherwise stay.
  - COUNT:
    - If cnt==0, go to DONE on the next clk, regardless of cpu_cen.
    - Otherwise, on cpu_cen, cnt ← cnt−1.
    - If ABORT=1 and ~free_mask[sel] and ~blank, go to WAIT. cnt is reloaded on the next entry to COUNT.
    - The abort check takes priority over the decrement and over completion.
  - DONE: busy=0 and grant is held. When any_cs=0, go to IDLE and clear grant.
- In WAIT or COUNT, any_cs=0 (CPU abandoned the cycle) forces IDLE and grant=0. wait_cnt holds its value.
- wait_cnt increments on cpu_cen while in WAIT or COUNT, and saturates at 16'hFFFF. It holds its value in DONE and IDLE until the next access start.
- free_mask is sampled only via sel while the access is active. A change mid-access takes effect at the next clk.
- Back-to-back accesses: a new start requires cs to fall for at least one clk. cs held continuously across two CPU cycles counts as a single access.
- DLY=0: blank or free access takes 2 clks from start to DONE (IDLE→COUNT→DONE).

Test Plan:
- Blank-gated access: LVBL=1, LHBL=1, cs=4'b0001, free_mask=0, cpu_cen every 4th clk → busy=1 held; after LVBL=0 at clk N, state leaves WAIT; busy=0 after DLY=2 cen ticks plus one clk; grant=4'b0001.
- Free channel: free_mask=4'b0100, cs=4'b0100, active display (no blank) → grant=4'b0100; busy low after 2 cen ticks; wait_cnt=2.
- Abort: HBLANK_OK=1, cs=1 starts during hblank, LHBL returns to 1 after 1 cen tick → back to WAIT with busy=1; completes in the next hblank; wait_cnt counts the whole stall.
- Multi-select: cs=4'b0110 at start → grant=4'b0010, multi_err=1; multi_err stays set after cs drops; cleared only by rst=0.
- Cancel and reset: cs drops while in WAIT → IDLE, grant=0, busy=0. Separately, rst=0 pulsed in COUNT → all outputs zero on the next clk.
- Saturation: blank held off for more than 65535 cen ticks with cs asserted → wait_cnt=16'hFFFF and does not wrap.
